// File: rtl/inst_encoder.sv
// Packs decoded instruction fields into 32-bit words and streams them into
// instruction memory at consecutive word addresses, flagging illegal opcodes and off-page jumps.
module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [3:0]       in_rd,
    input  logic [3:0]       in_rs1,
    input  logic [3:0]       in_rs2,
    input  logic [15:0]      in_imm16,
    input  logic [1:0]       in_mode,
    input  logic [31:0]      in_target,
    input  logic             in_last,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q;
    logic               wvalid_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        acc_addr_q;
    logic [1:0]         err_code_q;
    logic [CNT_W-1:0]   count_q;

    logic [31:0]        word_d;
    logic               bad_op_d;
    logic               bad_page_d;
    logic               accept;
    logic               retire;

    // Field packing mirrors the instruction register's unpacking layout.
    always_comb begin
        word_d     = 32'd0;
        bad_op_d   = 1'b0;
        bad_page_d = 1'b0;
        if (in_opcode[5:2] == 4'b0000 && in_opcode != 6'b000011) begin
            word_d = {in_opcode, in_rd, in_rs1, in_rs2, 14'd0};
        end else if (in_opcode[5:2] == 4'b0001 || in_opcode[5:2] == 4'b0010 ||
                     in_opcode == 6'b000011) begin
            word_d = {in_opcode, in_rd, in_rs1, in_imm16, in_mode};
        end else if (in_opcode == 6'b001100 || in_opcode == 6'b001101) begin
            word_d     = {in_opcode, in_target[25:0]};
            bad_page_d = (in_target[31:26] != acc_addr_q[31:26]);
        end else if (in_opcode == 6'b001111 || in_opcode == 6'b010000) begin
            word_d = {in_opcode, in_rd, 22'd0};
        end else begin
            bad_op_d = 1'b1;
        end
    end

    assign in_ready  = (state_q == S_RUN) && (!wvalid_q || mem_ack);
    assign accept    = in_valid && in_ready;
    assign retire    = wvalid_q && mem_ack;

    assign mem_we    = wvalid_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign err_code  = err_code_q;
    assign count     = count_q;

    // A new legal beat overrides a same-cycle retire so the output slot never bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wvalid_q   <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            acc_addr_q <= 32'd0;
            err_code_q <= 2'b00;
            count_q    <= '0;
        end else begin
            if (retire) begin
                wvalid_q <= 1'b0;
                if (count_q != '1) begin
                    count_q <= count_q + 1'b1;
                end
            end
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        acc_addr_q <= base_addr;
                        err_code_q <= 2'b00;
                        count_q    <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (bad_op_d || bad_page_d) begin
                            err_code_q <= bad_op_d ? 2'b01 : 2'b10;
                            state_q    <= S_DRAIN;
                        end else begin
                            wvalid_q   <= 1'b1;
                            addr_q     <= acc_addr_q;
                            wdata_q    <= word_d;
                            acc_addr_q <= acc_addr_q + 32'd1;
                            if (in_last) begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!wvalid_q) begin
                        state_q <= (err_code_q != 2'b00) ? S_ERR : S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and loader for the 32-bit core. It accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit words using the same field layout the instruction register unpacks. It writes the words into instruction memory at consecutive word addresses starting from a programmable base. It sits between the test/boot loader and the instruction memory write port, and it checks each instruction for illegal opcodes and out-of-page jump targets.

## Interface
Parameters:
- CNT_W, 16, width of the written-word counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load session; sampled in IDLE/DONE/ERR only
- base_addr  in  32  first word address of the session; sampled with start
- in_valid  in  1  field beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_opcode  in  6  opcode
- in_rd, in_rs1, in_rs2  in  4 each  register fields
- in_imm16  in  16  immediate
- in_mode  in  2  I-type mode
- in_target  in  32  absolute J-type target
- in_last  in  1  final beat of session
- mem_we  out  1  write request; held until mem_ack
- mem_addr  out  32  word address
- mem_wdata  out  32  encoded word
- mem_ack  in  1  memory took the write this cycle
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- err  out  1  state is ERR
- err_code  out  2  01 illegal opcode, 10 jump page mismatch, 00 none
- count  out  CNT_W  words written this session

## Operation
- States: IDLE, RUN, DRAIN, DONE, ERR.
- Transitions out of IDLE/DONE/ERR:
  - start goes to RUN.
  - acc_addr loads base_addr.
  - count and err_code clear.
- Encoding by opcode:
  - R-type: op[5:2]==0000 and op!=000011. Word is {op, rd, rs1, rs2, 14'b0}.
  - I-type: op[5:2]==0001, op[5:2]==0010, or op==000011. Word is {op, rd, rs1, imm16, mode}.
  - J-type: op 001100 (JMP) or 001101 (CALL). Word is {op, target[25:0]}. Legal only when target[31:26]==acc_addr[31:26].
  - S-type: op 001111 (PUSH) or 010000 (POP). Word is {op, rd, 22'b0}.
  - Any other opcode is illegal.
- One-entry output register (wvalid, mem_addr, mem_wdata). mem_we = wvalid.
- in_ready = (state==RUN) && (!wvalid || mem_ack).
- Legal accepted beat:
  - The encoded word and acc_addr load into the output register.
  - acc_addr increments by 1, wrapping modulo 2^32.
  - If in_last is set, go to DRAIN.
- Illegal accepted beat:
  - The beat is consumed but not written.
  - acc_addr is unchanged.
  - err_code is set and the state goes to DRAIN_ERR behaviour: wait until wvalid clears, then go to ERR.
  - err_code is sticky until start or reset.
- DRAIN: go to DONE when wvalid==0, or to ERR if err_code!=0.
- count increments on each mem_we && mem_ack and saturates at all-ones.
- start is ignored in RUN and DRAIN.

## Timing
- Reset state: IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, err_code=00, count=0. Reset takes effect mid-session; a pending write is dropped.
- Accept at edge T: mem_we is high from T+1. mem_we stays high and mem_addr/mem_wdata stay stable until the edge where mem_ack=1.
- Simultaneous retire and accept: when mem_ack and a new accept occur in the same cycle, the new word replaces the old one. Throughput is 1 word/cycle with mem_ack tied high.
- Completion: done rises 1 cycle after the last write retires, and stays high until start.
- Illegal beat with a pending write: the pending write completes normally before err rises.
- start while in DONE/ERR: busy goes high at the next edge, and in_ready can go high in that same cycle.

## Test plan
- R-type: base=0, op=000000, rd=1, rs1=2, rs2=3, mem_ack=1 -> mem_addr=0, mem_wdata=0x0048C000, count=1, done after in_last.
- I-type then PUSH back-to-back:
  - Beat 1: op=000100, rd=5, rs1=6, imm=0x1234, mode=2.
  - Beat 2: op=001111, rd=7.
  - Expected: words 0x115848D2 at addr 0 and 0x3DC00000 at addr 1, in consecutive cycles.
- JMP legal: base=0, target=0x00000100 -> word 0x30000100. JMP illegal: target=0x04000000 -> no write, err=1, err_code=10.
- Illegal opcode 111111 after two legal beats with mem_ack delayed 3 cycles -> both legal words written, no third write, err_code=01, count=2.
- Backpressure: hold mem_ack=0 for 5 cycles -> in_ready=0 after one accept; mem_we, mem_addr and mem_wdata stay stable; no beat is lost.
- Reset mid-session, then start with base=0x10 -> mem_we drops on reset, count=0, first write goes to addr 0x10.
